// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state encoding and datapath select codes for multicycle_ctrl_ws
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMREAD = 5'd3,
    S_MEMWR   = 5'd4,
    S_MEMWB   = 5'd5,
    S_EXECR   = 5'd6,
    S_EXECI   = 5'd7,
    S_JAL     = 5'd8,
    S_JALR    = 5'd9,
    S_BRANCH  = 5'd10,
    S_AUIPC   = 5'd11,
    S_LUI     = 5'd12,
    S_ALUWB   = 5'd13,
    S_HALT    = 5'd14,
    S_TRAP    = 5'd15
  } state_t;

  localparam logic [2:0] SRC_A_PC    = 3'b000;
  localparam logic [2:0] SRC_A_RS1   = 3'b001;
  localparam logic [2:0] SRC_A_OLDPC = 3'b010;
  localparam logic [2:0] SRC_A_ZERO  = 3'b011;

  localparam logic [2:0] SRC_B_RS2   = 3'b000;
  localparam logic [2:0] SRC_B_FOUR  = 3'b001;
  localparam logic [2:0] SRC_B_IMM   = 3'b010;

  localparam logic [2:0] RES_ALUOUT  = 3'b000;
  localparam logic [2:0] RES_MEMDATA = 3'b001;

  localparam logic [1:0] ADR_PC      = 2'b00;
  localparam logic [1:0] ADR_ALUOUT  = 2'b01;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_BRANCH  = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  localparam logic [1:0] SIZE_NONE   = 2'b00;
  localparam logic [1:0] SIZE_WORD   = 2'b10;

  // The reserved size code 11 is accessed as a word so 11 never reaches the bus.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? SIZE_WORD : f3[1:0];
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - saturating memory wait-state counter with clear and done flag
module mem_wait_cnt #(
  parameter int MAX = 255,
  parameter int W   = (MAX < 2) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !done) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_ws.sv
// rtl/multicycle_ctrl_ws.sv - multicycle RV32I control FSM with memory wait states; CTRL_TRAP_EN enables TRAP
module multicycle_ctrl_ws
  import ctrl_pkg::*;
#(
  parameter int SEL_W       = 3,
  parameter int ADR_W       = 2,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               mem_req,
  output logic [1:0]         mem_size,
  output logic               load_unsigned,
  output logic               pc_write,
  output logic               ir_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               imm,
  output logic               mem_write,
  output logic               branch,
  output logic [ADR_W-1:0]   adr_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [SEL_W-1:0]   alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [SEL_W-1:0]   result_src,
  output logic               retire,
  output logic               halted,
  output logic               trap
);

  state_t state_q;
  state_t state_d;
  logic   wait_done;
  logic   mem_timeout;

  mem_wait_cnt #(
    .MAX (MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .inc   (mem_req && !mem_ready),
    .done  (wait_done)
  );

`ifdef CTRL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
  assign mem_timeout = wait_done;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
  logic unused_wait_done;
  assign unused_wait_done = wait_done;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (mem_timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          OP_SYSTEM:         state_d = S_HALT;
          default:           state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (mem_timeout) state_d = S_TRAP;
      end
      S_MEMWR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (mem_timeout) state_d = S_TRAP;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_JAL:     state_d = S_ALUWB;
      S_JALR:    state_d = S_ALUWB;
      S_BRANCH:  state_d = S_FETCH;
      S_AUIPC:   state_d = S_ALUWB;
      S_LUI:     state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_HALT:    state_d = resume ? S_FETCH : S_HALT;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_size      = SIZE_NONE;
    load_unsigned = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    imm           = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    adr_src       = ADR_W'(ADR_PC);
    alu_op        = ALUOP_W'(ALU_ADD);
    alu_src_a     = SEL_W'(SRC_A_PC);
    alu_src_b     = SEL_W'(SRC_B_RS2);
    result_src    = SEL_W'(RES_ALUOUT);
    retire        = 1'b0;
    halted        = 1'b0;
    trap          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_size  = SIZE_WORD;
        alu_src_b = SEL_W'(SRC_B_FOUR);
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SEL_W'(SRC_A_OLDPC);
        alu_src_b = SEL_W'(SRC_B_IMM);
      end
      S_MEMADR: begin
        alu_src_a = SEL_W'(SRC_A_RS1);
        alu_src_b = SEL_W'(SRC_B_IMM);
      end
      S_MEMREAD: begin
        mem_req       = 1'b1;
        adr_src       = ADR_W'(ADR_ALUOUT);
        mem_size      = access_size(funct3);
        load_unsigned = funct3[2];
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        adr_src   = ADR_W'(ADR_ALUOUT);
        mem_size  = access_size(funct3);
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_MEMWB: begin
        reg_write     = 1'b1;
        result_src    = SEL_W'(RES_MEMDATA);
        load_unsigned = funct3[2];
        retire        = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SEL_W'(SRC_A_RS1);
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_EXECI: begin
        alu_src_a = SEL_W'(SRC_A_RS1);
        alu_src_b = SEL_W'(SRC_B_IMM);
        alu_op    = ALUOP_W'(ALU_FUNCT);
        imm       = 1'b1;
      end
      S_JAL, S_JALR: begin
        // ALU computes the link value oldPC+4 while the target loads into PC.
        alu_src_a = SEL_W'(SRC_A_OLDPC);
        alu_src_b = SEL_W'(SRC_B_FOUR);
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        imm       = (state_q == S_JALR);
      end
      S_BRANCH: begin
        alu_src_a = SEL_W'(SRC_A_RS1);
        alu_op    = ALUOP_W'(ALU_BRANCH);
        branch    = 1'b1;
        pc_src    = 1'b1;
        retire    = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a = SEL_W'(SRC_A_OLDPC);
        alu_src_b = SEL_W'(SRC_B_IMM);
      end
      S_LUI: begin
        alu_src_a = SEL_W'(SRC_A_ZERO);
        alu_src_b = SEL_W'(SRC_B_IMM);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_TRAP: begin
`ifdef CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule
